// File: rtl/shifter_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shifter_operand_sequencer
// Description : Builds the ARM data-processing shifter_operand / carry-out by
//               sequencing Rm/Rs reads and driving an external barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_operand_sequencer #(
    parameter int RF_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_i_bit,
    input  logic [11:0]          in_operand2,
    input  logic                 in_carry,
    output logic                 rf_en,
    output logic [RF_ADDR_W-1:0] rf_addr,
    input  logic [31:0]          rf_data,
    output logic [31:0]          bs_data,
    output logic [31:0]          bs_shift_value,
    output logic [2:0]           bs_op_select,
    output logic                 bs_carry,
    input  logic [31:0]          bs_result,
    input  logic                 bs_carry_out,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_operand,
    output logic                 out_carry
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_RM = 3'd1,
        S_RD_RS = 3'd2,
        S_CAP   = 3'd3,
        S_EXEC  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic [2:0] c_OP_LSL = 3'b000;
    localparam logic [2:0] c_OP_LSR = 3'b001;
    localparam logic [2:0] c_OP_ASR = 3'b010;
    localparam logic [2:0] c_OP_ROR = 3'b011;
    localparam logic [2:0] c_OP_RRX = 3'b100;

    state_t      r_state;
    state_t      w_next;
    logic        r_i_bit;
    logic [11:0] r_op2;
    logic        r_carry;
    logic [31:0] r_rm_q;
    logic [7:0]  r_rs_q;
    logic [31:0] r_out_operand;
    logic        r_out_carry;

    logic        w_reg_shift;
    logic [4:0]  w_shift_imm;
    logic [1:0]  w_shift_type;
    logic        w_accept;

    assign w_reg_shift  = r_op2[4];
    assign w_shift_imm  = r_op2[11:7];
    assign w_shift_type = r_op2[6:5];
    assign w_accept     = (r_state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = in_i_bit ? S_EXEC : S_RD_RM;
            S_RD_RM: w_next = w_reg_shift ? S_RD_RS : S_CAP;
            S_RD_RS: w_next = S_CAP;
            S_CAP:   w_next = S_EXEC;
            S_EXEC:  w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Pipeline flush wins over every other transition, including out_ready
        if (abort) w_next = S_IDLE;
    end

    always_comb begin
        rf_en   = 1'b0;
        rf_addr = '0;
        case (r_state)
            S_RD_RM: begin
                rf_en   = 1'b1;
                rf_addr = RF_ADDR_W'(r_op2[3:0]);
            end
            S_RD_RS: begin
                rf_en   = 1'b1;
                rf_addr = RF_ADDR_W'(r_op2[11:8]);
            end
            default: ;
        endcase
    end

    always_comb begin
        bs_data        = '0;
        bs_shift_value = '0;
        bs_op_select   = c_OP_LSL;
        bs_carry       = 1'b0;
        if (r_state == S_EXEC) begin
            bs_carry = r_carry;
            if (r_i_bit) begin
                bs_data        = {24'b0, r_op2[7:0]};
                bs_op_select   = c_OP_ROR;
                bs_shift_value = {27'b0, r_op2[11:8], 1'b0};
            end else if (w_reg_shift) begin
                bs_data        = r_rm_q;
                bs_op_select   = {1'b0, w_shift_type};
                bs_shift_value = {24'b0, r_rs_q};
            end else begin
                bs_data = r_rm_q;
                // A zero immediate amount re-encodes LSR/ASR as 32 and ROR as RRX
                case (w_shift_type)
                    2'b00: begin
                        bs_op_select   = c_OP_LSL;
                        bs_shift_value = {27'b0, w_shift_imm};
                    end
                    2'b01: begin
                        bs_op_select   = c_OP_LSR;
                        bs_shift_value = (w_shift_imm == 5'd0) ? 32'd32 : {27'b0, w_shift_imm};
                    end
                    2'b10: begin
                        bs_op_select   = c_OP_ASR;
                        bs_shift_value = (w_shift_imm == 5'd0) ? 32'd32 : {27'b0, w_shift_imm};
                    end
                    default: begin
                        if (w_shift_imm == 5'd0) begin
                            bs_op_select   = c_OP_RRX;
                            bs_shift_value = 32'd1;
                        end else begin
                            bs_op_select   = c_OP_ROR;
                            bs_shift_value = {27'b0, w_shift_imm};
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_bit       <= 1'b0;
            r_op2         <= '0;
            r_carry       <= 1'b0;
            r_rm_q        <= '0;
            r_rs_q        <= '0;
            r_out_operand <= '0;
            r_out_carry   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_i_bit <= in_i_bit;
                r_op2   <= in_operand2;
                r_carry <= in_carry;
            end
            if (r_state == S_RD_RS) begin
                r_rm_q <= rf_data;
            end
            if (r_state == S_CAP) begin
                if (w_reg_shift) r_rs_q <= rf_data[7:0];
                else             r_rm_q <= rf_data;
            end
            if ((r_state == S_EXEC) && !abort) begin
                r_out_operand <= bs_result;
                r_out_carry   <= bs_carry_out;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_state == S_OUT);
    assign out_operand = r_out_operand;
    assign out_carry   = r_out_carry;

endmodule
`default_nettype wire

// File: tb/tb_shifter_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_operand_sequencer
// Description : Self-checking bench with register-file and barrel-shifter
//               models plus an ARM shifter_operand reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_i_bit = 1'b0;
    logic [11:0] in_operand2 = '0;
    logic        in_carry = 1'b0;
    logic        rf_en;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data = '0;
    logic [31:0] bs_data;
    logic [31:0] bs_shift_value;
    logic [2:0]  bs_op_select;
    logic        bs_carry;
    logic [31:0] bs_result;
    logic        bs_carry_out;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_operand;
    logic        out_carry;

    int total = 0;
    int bad   = 0;
    logic [31:0] rf [16];

    shifter_operand_sequencer #(.RF_ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_i_bit(in_i_bit), .in_operand2(in_operand2), .in_carry(in_carry),
        .rf_en(rf_en), .rf_addr(rf_addr), .rf_data(rf_data),
        .bs_data(bs_data), .bs_shift_value(bs_shift_value),
        .bs_op_select(bs_op_select), .bs_carry(bs_carry),
        .bs_result(bs_result), .bs_carry_out(bs_carry_out),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_operand(out_operand), .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    // One-port register file: data one cycle after the strobe, garbage otherwise
    always @(posedge clk) rf_data <= rf_en ? rf[rf_addr] : $urandom;

    // Generic ARM shift semantics, returns {carry, result}
    function automatic logic [32:0] shift_fn(input logic [2:0] op, input logic [31:0] amt,
                                             input logic [31:0] v, input logic c);
        logic [63:0] w;
        logic [31:0] r;
        int k;
        int m;
        k = int'(amt[8:0]);
        case (op)
            3'b000: begin
                if (k == 0) return {c, v};
                if (k < 32) begin w = {32'b0, v} << k; return {w[32], w[31:0]}; end
                if (k == 32) return {v[0], 32'b0};
                return 33'b0;
            end
            3'b001: begin
                if (k == 0) return {c, v};
                if (k < 32) begin w = {v, 32'b0} >> k; return {w[31], w[63:32]}; end
                if (k == 32) return {v[31], 32'b0};
                return 33'b0;
            end
            3'b010: begin
                if (k == 0) return {c, v};
                if (k < 32) begin
                    w = {v, 32'b0} >> k;
                    r = $signed(v) >>> k;
                    return {w[31], r};
                end
                return {v[31], {32{v[31]}}};
            end
            3'b011: begin
                if (k == 0) return {c, v};
                m = k % 32;
                if (m == 0) return {v[31], v};
                r = (v >> m) | (v << (32 - m));
                return {r[31], r};
            end
            3'b100:  return {v[0], c, v[31:1]};
            default: return {c, v};
        endcase
    endfunction

    always_comb {bs_carry_out, bs_result} = shift_fn(bs_op_select, bs_shift_value, bs_data, bs_carry);

    // Expected {carry, operand} straight from the instruction encoding
    function automatic logic [32:0] ref_model(input logic ib, input logic [11:0] op2, input logic c,
                                              input logic [31:0] rm, input logic [31:0] rs);
        logic [31:0] x;
        logic [31:0] r;
        logic [31:0] n;
        int rot;
        if (ib) begin
            x   = {24'b0, op2[7:0]};
            rot = 2 * int'(op2[11:8]);
            r   = (rot == 0) ? x : ((x >> rot) | (x << (32 - rot)));
            return {(rot == 0) ? c : r[31], r};
        end
        if (op2[4]) begin
            n = {24'b0, rs[7:0]};
            return shift_fn({1'b0, op2[6:5]}, n, rm, c);
        end
        n = {27'b0, op2[11:7]};
        case (op2[6:5])
            2'b00:   return shift_fn(3'b000, n, rm, c);
            2'b01:   return (n == 0) ? {rm[31], 32'b0} : shift_fn(3'b001, n, rm, c);
            2'b10:   return (n == 0) ? {rm[31], {32{rm[31]}}} : shift_fn(3'b010, n, rm, c);
            default: return (n == 0) ? {rm[0], c, rm[31:1]} : shift_fn(3'b011, n, rm, c);
        endcase
    endfunction

    function automatic int exp_latency(input logic ib, input logic [11:0] op2);
        if (ib) return 2;
        return op2[4] ? 5 : 4;
    endfunction

    task automatic scramble();
        start       = 1'($urandom_range(0, 1));
        in_i_bit    = 1'($urandom_range(0, 1));
        in_operand2 = 12'($urandom);
        in_carry    = 1'($urandom_range(0, 1));
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
    endtask

    // Drives one operation from IDLE and reports what was observed
    task automatic run_op(input logic ib, input logic [11:0] op2, input logic c, input int hold,
                          output int lat, output logic [32:0] res, output int nrd,
                          output logic [3:0] addr0, output logic [3:0] addr1,
                          output logic [2:0] xop, output logic [31:0] xsv,
                          output logic hold_ok, output logic idle_ok);
        logic [2:0]  pop;
        logic [31:0] psv;
        nrd = 0; addr0 = '0; addr1 = '0; pop = '0; psv = '0;
        hold_ok = 1'b1; idle_ok = 1'b0;
        in_i_bit = ib; in_operand2 = op2; in_carry = c; start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        start = 1'b0;
        while (!out_valid && lat < 20) begin
            if (rf_en) begin
                if (nrd == 0) addr0 = rf_addr; else addr1 = rf_addr;
                nrd++;
            end
            pop = bs_op_select;
            psv = bs_shift_value;
            scramble();
            @(posedge clk); #1;
            lat++;
        end
        xop = pop;
        xsv = psv;
        res = {out_carry, out_operand};
        for (int i = 0; i < hold; i++) begin
            scramble();
            @(posedge clk); #1;
            if (!out_valid || !busy || ({out_carry, out_operand} !== res)) hold_ok = 1'b0;
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idle_ok = !busy && !out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({rf_en, busy, out_valid, out_operand, out_carry, bs_data, bs_shift_value, bs_op_select} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b busy=%b valid=%b op=%h c=%b, required all zero",
                     rf_en, busy, out_valid, out_operand, out_carry);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_immediate();
        int lat; logic [32:0] res; int nrd; logic [3:0] a0, a1; logic [2:0] xop; logic [31:0] xsv;
        logic hok, iok; logic [11:0] op2; logic c;
        run_op(1'b1, 12'h1FF, 1'b0, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== {1'b1, 32'hC000003F}) begin
            bad++; $display("FAIL imm_value: got %h required %h", res, {1'b1, 32'hC000003F});
        end
        total++;
        if (lat !== 2 || nrd !== 0) begin
            bad++; $display("FAIL imm_timing: got latency=%0d reads=%0d required 2 and 0", lat, nrd);
        end
        for (int i = 0; i < 8; i++) begin
            op2 = 12'($urandom);
            c   = 1'($urandom_range(0, 1));
            run_op(1'b1, op2, c, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
            total++;
            if (res !== ref_model(1'b1, op2, c, 32'b0, 32'b0) || lat !== 2 || nrd !== 0) begin
                bad++;
                $display("FAIL imm_random op2=%h: got %h lat=%0d required %h lat=2",
                         op2, res, lat, ref_model(1'b1, op2, c, 32'b0, 32'b0));
            end
        end
    endtask

    task automatic test_imm_shift();
        int lat; logic [32:0] res; int nrd; logic [3:0] a0, a1; logic [2:0] xop; logic [31:0] xsv;
        logic hok, iok; logic [11:0] op2; logic c; logic [32:0] exp;
        randomize_rf();
        rf[2] = 32'h80000001;
        run_op(1'b0, 12'h022, 1'b0, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== {1'b1, 32'h0} || lat !== 4 || nrd !== 1 || a0 !== 4'd2) begin
            bad++;
            $display("FAIL lsr0: got %h lat=%0d reads=%0d addr=%0d required %h lat=4 reads=1 addr=2",
                     res, lat, nrd, a0, {1'b1, 32'h0});
        end
        rf[0] = 32'h00000003;
        run_op(1'b0, 12'h060, 1'b1, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== {1'b1, 32'h80000001} || xop !== 3'b100 || xsv !== 32'd1) begin
            bad++;
            $display("FAIL rrx: got %h op=%b amt=%0d required %h op=100 amt=1",
                     res, xop, xsv, {1'b1, 32'h80000001});
        end
        for (int i = 0; i < 10; i++) begin
            randomize_rf();
            op2 = 12'($urandom);
            op2[4] = 1'b0;
            if (i < 4) op2[11:7] = 5'd0;
            c = 1'($urandom_range(0, 1));
            exp = ref_model(1'b0, op2, c, rf[op2[3:0]], rf[op2[11:8]]);
            run_op(1'b0, op2, c, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
            total++;
            if (res !== exp || lat !== 4 || a0 !== op2[3:0]) begin
                bad++;
                $display("FAIL immshift_random op2=%h: got %h lat=%0d addr=%0d required %h lat=4 addr=%0d",
                         op2, res, lat, a0, exp, op2[3:0]);
            end
        end
    endtask

    task automatic test_reg_shift();
        int lat; logic [32:0] res; int nrd; logic [3:0] a0, a1; logic [2:0] xop; logic [31:0] xsv;
        logic hok, iok; logic [11:0] op2; logic c; logic [32:0] exp; logic [31:0] rsv;
        randomize_rf();
        rf[1] = 32'h00000001;
        rf[3] = 32'hABCD0120;
        run_op(1'b0, 12'h311, 1'b0, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== {1'b1, 32'h0} || lat !== 5 || nrd !== 2 || a0 !== 4'd1 || a1 !== 4'd3 || xsv !== 32'h20) begin
            bad++;
            $display("FAIL regshift_32: got %h lat=%0d reads=%0d addrs=%0d,%0d amt=%h required %h lat=5 addrs=1,3 amt=20",
                     res, lat, nrd, a0, a1, xsv, {1'b1, 32'h0});
        end
        rf[3] = 32'h00000100;
        c = 1'($urandom_range(0, 1));
        run_op(1'b0, 12'h311, c, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== {c, 32'h1}) begin
            bad++; $display("FAIL regshift_0: got %h required %h", res, {c, 32'h1});
        end
        for (int i = 0; i < 10; i++) begin
            randomize_rf();
            op2 = 12'($urandom);
            op2[4] = 1'b1;
            rsv = rf[op2[11:8]];
            case (i % 5)
                0: rsv[7:0] = 8'd0;
                1: rsv[7:0] = 8'd32;
                2: rsv[7:0] = 8'd33;
                3: rsv[7:0] = 8'($urandom_range(1, 31));
                default: rsv[7:0] = 8'($urandom);
            endcase
            rf[op2[11:8]] = rsv;
            c = 1'($urandom_range(0, 1));
            exp = ref_model(1'b0, op2, c, rf[op2[3:0]], rf[op2[11:8]]);
            run_op(1'b0, op2, c, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
            total++;
            if (res !== exp || lat !== 5 || a0 !== op2[3:0] || a1 !== op2[11:8]) begin
                bad++;
                $display("FAIL regshift_random op2=%h: got %h lat=%0d required %h lat=5", op2, res, lat, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [32:0] res; int nrd; logic [3:0] a0, a1; logic [2:0] xop; logic [31:0] xsv;
        logic hok, iok; logic [32:0] exp;
        randomize_rf();
        exp = ref_model(1'b0, 12'h145, 1'b1, rf[5], rf[1]);
        run_op(1'b0, 12'h145, 1'b1, 3, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (hok !== 1'b1 || res !== exp) begin
            bad++; $display("FAIL backpressure_hold: got stable=%b value=%h required stable=1 value=%h", hok, res, exp);
        end
        total++;
        if (iok !== 1'b1) begin
            bad++; $display("FAIL backpressure_release: got idle=%b required 1", iok);
        end
    endtask

    task automatic test_abort();
        int lat; logic [32:0] res; int nrd; logic [3:0] a0, a1; logic [2:0] xop; logic [31:0] xsv;
        logic hok, iok; int seen;
        randomize_rf();
        in_i_bit = 1'b0; in_operand2 = 12'h211; in_carry = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (bs_shift_value !== {24'b0, rf[2][7:0]} || bs_data !== rf[1]) begin
            bad++; $display("FAIL abort_exec_reached: got data=%h amt=%h required %h %h",
                            bs_data, bs_shift_value, rf[1], {24'b0, rf[2][7:0]});
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL abort_exec: got busy=%b valid=%b required 0 0", busy, out_valid);
        end
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL abort_no_result: got %0d valid cycles required 0", seen);
        end
        start = 1'b1; abort = 1'b1; in_i_bit = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL abort_start_idle: got busy=%b required 0", busy);
        end
        run_op(1'b0, 12'h2C3, 1'b1, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== ref_model(1'b0, 12'h2C3, 1'b1, rf[3], rf[2]) || lat !== 4) begin
            bad++; $display("FAIL abort_recover: got %h lat=%0d required %h lat=4",
                            res, lat, ref_model(1'b0, 12'h2C3, 1'b1, rf[3], rf[2]));
        end
    endtask

    task automatic test_reset_midop();
        int lat; logic [32:0] res; int nrd; logic [3:0] a0, a1; logic [2:0] xop; logic [31:0] xsv;
        logic hok, iok;
        randomize_rf();
        run_op(1'b1, 12'h0FF, 1'b1, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== {1'b1, 32'h000000FF}) begin
            bad++; $display("FAIL pre_reset_op: got %h required %h", res, {1'b1, 32'h000000FF});
        end
        in_i_bit = 1'b0; in_operand2 = 12'h311; in_carry = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rf_en !== 1'b1 || rf_addr !== 4'd3) begin
            bad++; $display("FAIL rd_rs_reached: got en=%b addr=%0d required 1 3", rf_en, rf_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({rf_en, rf_addr, busy, out_valid, out_operand, out_carry, bs_data, bs_shift_value, bs_op_select, bs_carry} !== '0) begin
            bad++;
            $display("FAIL async_reset: got en=%b busy=%b valid=%b op=%h c=%b required all zero",
                     rf_en, busy, out_valid, out_operand, out_carry);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 12'h311, 1'b1, 0, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
        total++;
        if (res !== ref_model(1'b0, 12'h311, 1'b1, rf[1], rf[3]) || lat !== 5) begin
            bad++; $display("FAIL post_reset_op: got %h lat=%0d required %h lat=5",
                            res, lat, ref_model(1'b0, 12'h311, 1'b1, rf[1], rf[3]));
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [32:0] res; int nrd; logic [3:0] a0, a1; logic [2:0] xop; logic [31:0] xsv;
        logic hok, iok; logic [11:0] op2; logic c; logic ib; logic [32:0] exp; int hold;
        for (int i = 0; i < 24; i++) begin
            randomize_rf();
            ib   = 1'($urandom_range(0, 1));
            op2  = 12'($urandom);
            c    = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 2);
            exp  = ref_model(ib, op2, c, rf[op2[3:0]], rf[op2[11:8]]);
            run_op(ib, op2, c, hold, lat, res, nrd, a0, a1, xop, xsv, hok, iok);
            total++;
            if (res !== exp || lat !== exp_latency(ib, op2) || hok !== 1'b1 || iok !== 1'b1) begin
                bad++;
                $display("FAIL b2b i=%b op2=%h: got %h lat=%0d stable=%b idle=%b required %h lat=%0d 1 1",
                         ib, op2, res, lat, hok, iok, exp, exp_latency(ib, op2));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        test_reset();
        test_immediate();
        test_imm_shift();
        test_reg_shift();
        test_backpressure();
        test_abort();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shifter_operand_sequencer.md
Name: shifter_operand_sequencer

Overview:
Multi-cycle controller that builds the ARM data-processing second operand (shifter_operand) and shifter carry-out for the execute stage. It decodes operand-2 fields, sequences up to two reads on a shared one-port register file (Rm, then Rs), and drives an external barrel_shifter with data, amount, op-select and carry. It registers the shifter result and offers it on a valid/ready output.

Parameters:
RF_ADDR_W, 4, register-file address width (r0..r15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
abort  in  1  synchronous flush to IDLE (pipeline flush)
in_i_bit  in  1  instruction bit 25 (1 = 32-bit immediate)
in_operand2  in  12  instruction bits [11:0]
in_carry  in  1  CPSR C flag snapshot
rf_en  out  1  register-file read strobe
rf_addr  out  RF_ADDR_W  register-file read address
rf_data  in  32  read data, valid exactly one cycle after rf_en
bs_data  out  32  to barrel_shifter in_data
bs_shift_value  out  32  to barrel_shifter shift_value
bs_op_select  out  3  to barrel_shifter (000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX)
bs_carry  out  1  to barrel_shifter in_carry
bs_result  in  32  from barrel_shifter out_shifted_data (combinational)
bs_carry_out  in  1  from barrel_shifter out_carry
busy  out  1  state != IDLE
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_operand  out  32  shifter_operand
out_carry  out  1  shifter_carry_out

Behaviour:
- Reset (async, rst_n=0): state IDLE; rf_en, out_valid, busy, out_operand, out_carry, internal rm_q/rs_q/fields all 0.
- FSM: IDLE, RD_RM, RD_RS, CAP, EXEC, OUT.
- IDLE + start: latch in_i_bit, in_operand2, in_carry. I=1 -> EXEC. I=0 -> RD_RM. No start -> stay.
- RD_RM: rf_en=1, rf_addr=op2[3:0]. Register shift (op2[4]=1) -> RD_RS, else -> CAP.
- RD_RS: rf_en=1, rf_addr=op2[11:8]; capture rf_data into rm_q; -> CAP.
- CAP: rf_en=0; capture rf_data into rm_q (immediate shift) or rs_q (register shift); -> EXEC.
- EXEC: drive bs_* from latched registers only; register bs_result/bs_carry_out into out_operand/out_carry at the end of the cycle; -> OUT.
- OUT: out_valid=1, out_operand/out_carry stable; out_ready=1 -> IDLE. A new start is only accepted from IDLE.
- Latency from start cycle T: immediate, out_valid at T+2; immediate shift, T+4; register shift, T+5.
- bs_carry = latched in_carry in every mode.
- Mode I=1: bs_data = {24'b0, op2[7:0]}, bs_op_select=ROR, bs_shift_value = {27'b0, op2[11:8], 1'b0}. rotate=0 gives shift 0, so carry = C.
- Mode immediate shift (I=0, op2[4]=0): shift_imm=op2[11:7], type=op2[6:5], bs_data=rm_q.
  - LSL #n: amount n (0 is passthrough).
  - LSR #0 and ASR #0 encode amount 32.
  - ROR #0 is RRX: op 100, amount 1.
  - ROR #n: amount n.
- Mode register shift (I=0, op2[4]=1): op=type, bs_data=rm_q, bs_shift_value = {24'b0, rs_q[7:0]}. rs_q[31:8] is ignored. Amount 0 yields Rm and C unchanged.
- bs_* outputs are 0 outside EXEC.
- abort: in any non-IDLE state -> IDLE next edge; out_valid drops; no result is produced. Abort has priority over out_ready. In IDLE, abort together with start means start is ignored.
- start or input changes while busy: ignored. Latched fields are not altered.
- rf_data is ignored in every state except RD_RS and CAP.

Test Plan:
- Immediate: I=1, op2=12'h1FF (rotate 1, imm8 FF), C=0 -> out_operand=0xC000003F, out_carry=1, out_valid at T+2, rf_en never asserted.
- LSR #0: I=0, op2=12'h022 (Rm=r2), r2=0x80000001 -> rf_addr=2 at T+1, operand=0x00000000, carry=1, out_valid at T+4.
- RRX: op2=12'h060 (ROR #0, Rm=r0), r0=0x00000003, C=1 -> bs_op_select=100, bs_shift_value=1, operand=0x80000001, carry=1.
- Register shift: op2=12'h311 (LSL by r3, Rm=r1), r1=0x00000001, r3=0xABCD0120 -> rf_addr 1 then 3; shift_value=0x20; operand=0, carry=1, out_valid at T+5. Repeat with r3=0x00000100 -> operand=0x00000001, carry=C.
- Backpressure: hold out_ready=0 for 3 cycles while pulsing start and changing inputs -> out_valid, out_operand, out_carry stable; busy=1. Raise out_ready -> IDLE next cycle; busy=0.
- Reset/abort: drop rst_n during RD_RS -> all outputs 0 immediately, without waiting for a clock. Abort in EXEC -> IDLE next edge, out_valid never asserts. A following start completes normally.
